// File: rtl/cqu_mips_pkg.sv
// Shared cqu_mips definitions: access-size encodings and the data-side
// memory interface state type.
package cqu_mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } dsif_state_t;

  // Encoding 11 behaves as a word access everywhere, including on the bus.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/data_sram_if_load_align.sv
// Load-data lane select and sign/zero extension for the data-side
// memory interface.
module load_align
  import cqu_mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_sign,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = i_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[i_addr_lo];
  assign w_half = i_addr_lo[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SIZE_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
      SIZE_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
      default:   ;
    endcase
  end

endmodule

// File: rtl/data_sram_if.sv
// Data-side sram-like bus interface for the cqu_mips memory stage.
// Optional misaligned-access trap: define DATA_SRAM_IF_ALIGN_CHECK_EN.
module data_sram_if
  import cqu_mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_sign_in,
  input  logic [DATA_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  input  logic              flush_in,
  input  logic              stage_stall_in,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              mem_done_out,
  output logic              mem_stall_out,
`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
  output logic              addr_err_out,
`endif
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [DATA_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);

  dsif_state_t       r_state;
  logic              r_discard;
  logic              r_req;
  logic              r_wr;
  logic              r_done;
  logic              r_sign;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_valid;
  logic [1:0]        w_size;
  logic [DATA_W-1:0] w_wdata_lanes;
  logic [DATA_W-1:0] w_load;

  assign w_valid = (mem_read_in | mem_write_in) & ~flush_in;
  assign w_size  = norm_size(mem_size_in);

  always_comb begin
    w_wdata_lanes = mem_wdata_in;
    case (w_size)
      SIZE_BYTE: w_wdata_lanes = {4{mem_wdata_in[7:0]}};
      SIZE_HALF: w_wdata_lanes = {2{mem_wdata_in[15:0]}};
      default:   ;
    endcase
  end

`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
  logic r_err;
  logic w_misaligned;

  assign w_misaligned = ((w_size == SIZE_HALF) & mem_addr_in[0]) |
                        ((w_size == SIZE_WORD) & (mem_addr_in[1:0] != 2'b00));
  assign addr_err_out = r_err;
`endif

  // Extension uses the size/address/sign latched at issue, not the live inputs.
  load_align #(.DATA_W(DATA_W)) u_load_align (
    .i_rdata   (data_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_size    (r_size),
    .i_sign    (r_sign),
    .o_data    (w_load)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state   <= IDLE;
      r_discard <= 1'b0;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_done    <= 1'b0;
      r_sign    <= 1'b0;
      r_size    <= 2'b00;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_wr      <= mem_write_in;
            r_size    <= w_size;
            r_sign    <= mem_sign_in;
            r_addr    <= mem_addr_in;
            r_wdata   <= w_wdata_lanes;
            r_discard <= 1'b0;
`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
            if (w_misaligned) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end
`else
            r_state <= REQ;
            r_req   <= 1'b1;
`endif
          end
        end
        REQ: begin
          // A flushed request stays on the bus until accepted, then drains.
          if (flush_in) r_discard <= 1'b1;
          if (data_addr_ok) begin
            r_req   <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (flush_in) r_discard <= 1'b1;
          if (data_data_ok) begin
            if (r_discard | flush_in) begin
              r_state   <= IDLE;
              r_discard <= 1'b0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_rdata <= r_wr ? '0 : w_load;
            end
          end
        end
        DONE: begin
          if (flush_in | ~stage_stall_in) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
            r_err   <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_stall_out = ((r_state == IDLE) & w_valid) | (r_state == REQ) | (r_state == WAIT);
  assign mem_done_out  = r_done;
  assign mem_rdata_out = r_rdata;
  assign data_req      = r_req;
  assign data_wr       = r_wr;
  assign data_size     = r_size;
  assign data_addr     = r_addr;
  assign data_wdata    = r_wdata;

endmodule

// File: tb/tb_data_sram_if.sv
// Self-checking bench for data_sram_if: directed vector table, hand-written
// flush/reset/misalign sequences and randomized transactions vs a reference model.
module tb_data_sram_if;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read_in, mem_write_in, mem_sign_in, flush_in, stage_stall_in;
  logic [1:0]  mem_size_in;
  logic [31:0] mem_addr_in, mem_wdata_in;
  logic [31:0] mem_rdata_out;
  logic        mem_done_out, mem_stall_out;
`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
  logic        addr_err_out;
`endif
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_sram_if #(.DATA_W(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .mem_size_in    (mem_size_in),
    .mem_sign_in    (mem_sign_in),
    .mem_addr_in    (mem_addr_in),
    .mem_wdata_in   (mem_wdata_in),
    .flush_in       (flush_in),
    .stage_stall_in (stage_stall_in),
    .mem_rdata_out  (mem_rdata_out),
    .mem_done_out   (mem_done_out),
    .mem_stall_out  (mem_stall_out),
`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
    .addr_err_out   (addr_err_out),
`endif
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_rdata     (data_rdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // Reference model: plain shift/mask arithmetic on the bus word.
  function automatic logic [31:0] ref_load(input logic [31:0] bus, input logic [31:0] addr,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (bus >> (int'(addr[1:0]) * 8)) & 32'hFF;
      if (sg && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      v = (bus >> (int'(addr[1]) * 16)) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = bus;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  task automatic idle_inputs();
    mem_read_in = 0; mem_write_in = 0; flush_in = 0; stage_stall_in = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
  endtask

  // One access with a modelled bus slave: addr_ok after adly extra REQ cycles,
  // data_ok ddly cycles after that, stage stall held for hold cycles in DONE,
  // optional flush pulse at cycle flush_cyc (-1 = none).
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] bus,
                         input int adly, input int ddly, input int hold, input int flush_cyc,
                         input logic [31:0] exp_rdata, input logic [31:0] exp_wdata);
    int exp_done, dok_cyc, limit, req_cnt, first_req, done_cyc, phase, dwait;
    bit flushed, stall_ok, done_ok, stable_ok, extra_req, hold_ok, exp_dn;
    logic [31:0] a_addr, a_wdata, got_rdata;
    logic [1:0]  a_size;
    logic        a_wr;
    exp_done = 3 + adly + ddly;
    dok_cyc  = 2 + adly + ddly;
    flushed  = (flush_cyc >= 0);
    limit    = flushed ? dok_cyc + 4 : exp_done + hold + 2;
    req_cnt = 0; first_req = -1; done_cyc = -1; phase = 0; dwait = 0;
    stall_ok = 1; done_ok = 1; stable_ok = 1; extra_req = 0; hold_ok = 1;
    a_addr = '0; a_wdata = '0; a_size = '0; a_wr = 0; got_rdata = '0;
    for (int c = 0; c <= limit; c++) begin
      @(posedge clk); #1;
      mem_read_in  = (c == 0) & rd;
      mem_write_in = (c == 0) & wr;
      if (c == 0) begin
        mem_size_in = sz; mem_sign_in = sg; mem_addr_in = addr; mem_wdata_in = wdata;
      end
      flush_in       = (c == flush_cyc);
      stage_stall_in = !flushed && c >= exp_done && c < exp_done + hold;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
      if (data_req) begin
        if (phase != 0) extra_req = 1;
        else begin
          if (req_cnt == 0) begin
            first_req = c; a_addr = data_addr; a_wdata = data_wdata;
            a_size = data_size; a_wr = data_wr;
          end else if ({data_addr, data_wdata, data_size, data_wr} !== {a_addr, a_wdata, a_size, a_wr}) begin
            stable_ok = 0;
          end
          req_cnt++;
          if (req_cnt == adly + 1) begin data_addr_ok = 1; phase = 1; end
        end
      end else if (phase == 1) begin
        if (dwait == ddly) begin data_data_ok = 1; data_rdata = bus; phase = 2; end
        dwait++;
      end
      @(negedge clk);
      if (mem_stall_out !== (flushed ? (c <= dok_cyc) : (c < exp_done))) stall_ok = 0;
      exp_dn = !flushed && c >= exp_done && c <= exp_done + hold;
      if (mem_done_out !== exp_dn) done_ok = 0;
      if (mem_done_out === 1'b1 && done_cyc < 0) begin
        done_cyc = c; got_rdata = mem_rdata_out;
      end else if (mem_done_out === 1'b1 && mem_rdata_out !== got_rdata) begin
        hold_ok = 0;
      end
    end
    idle_inputs();
    check({tag, ".stall_pattern"}, 32'(stall_ok), 32'd1);
    check({tag, ".done_pattern"}, 32'(done_ok), 32'd1);
    check({tag, ".req_stable"}, 32'(stable_ok), 32'd1);
    check({tag, ".no_extra_req"}, 32'(extra_req), 32'd0);
    check({tag, ".first_req_cyc"}, 32'(first_req), 32'd1);
    check({tag, ".req_cycles"}, 32'(req_cnt), 32'(adly + 1));
    check({tag, ".done_cyc"}, 32'(done_cyc), flushed ? 32'hFFFFFFFF : 32'(exp_done));
    if (!flushed) begin
      check({tag, ".data_addr"}, a_addr, addr);
      check({tag, ".data_wr"}, 32'(a_wr), 32'(wr));
      check({tag, ".data_size"}, 32'(a_size), 32'(sz));
      if (wr) check({tag, ".data_wdata"}, a_wdata, exp_wdata);
      if (rd) check({tag, ".rdata"}, got_rdata, exp_rdata);
      check({tag, ".rdata_held"}, 32'(hold_ok), 32'd1);
    end
    $display("txn %-10s rd=%0d wr=%0d sz=%0d addr=%08h adly=%0d ddly=%0d hold=%0d flush@%0d done@%0d rdata=%08h",
             tag, rd, wr, sz, addr, adly, ddly, hold, flush_cyc, done_cyc, got_rdata);
  endtask

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr, wdata, bus;
    int          adly, ddly, hold;
    logic [31:0] exp_rdata, exp_wdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic        rd, sg;
    logic [1:0]  sz;
    logic [31:0] addr, wd, bus;
    int          adly, ddly, hold;

    vecs[0] = '{"sw_word",  0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{"lb_sx",    1, 0, 2'd0, 1, 32'h103, 32'h0,        32'h80112233, 0, 0, 0, 32'hFFFFFF80, 32'h0};
    vecs[2] = '{"lbu",      1, 0, 2'd0, 0, 32'h103, 32'h0,        32'h80112233, 0, 0, 0, 32'h00000080, 32'h0};
    vecs[3] = '{"sh_dly",   0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 32'h0,        3, 0, 0, 32'h0,        32'hABCDABCD};
    vecs[4] = '{"lh_hold",  1, 0, 2'd1, 1, 32'h102, 32'h0,        32'h80112233, 0, 0, 2, 32'hFFFF8011, 32'h0};
    vecs[5] = '{"lb_lane0", 1, 0, 2'd0, 1, 32'h100, 32'h0,        32'h80112233, 0, 0, 0, 32'h00000033, 32'h0};
    vecs[6] = '{"lw_dly",   1, 0, 2'd2, 0, 32'h104, 32'h0,        32'h12345678, 0, 2, 0, 32'h12345678, 32'h0};
    vecs[7] = '{"sb",       0, 1, 2'd0, 0, 32'h101, 32'h1234565A, 32'h0,        1, 1, 0, 32'h0,        32'h5A5A5A5A};
    vecs[8] = '{"lh_sx_lo", 1, 0, 2'd1, 1, 32'h200, 32'h0,        32'h0000F00F, 2, 1, 1, 32'hFFFFF00F, 32'h0};

    idle_inputs();
    mem_size_in = 0; mem_sign_in = 0; mem_addr_in = 0; mem_wdata_in = 0;
    rstn = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.data_req", 32'(data_req), 32'd0);
    check("reset.data_wr", 32'(data_wr), 32'd0);
    check("reset.data_size", 32'(data_size), 32'd0);
    check("reset.data_addr", data_addr, 32'd0);
    check("reset.data_wdata", data_wdata, 32'd0);
    check("reset.rdata", mem_rdata_out, 32'd0);
    check("reset.done", 32'(mem_done_out), 32'd0);
    check("reset.stall", 32'(mem_stall_out), 32'd0);
`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
    check("reset.addr_err", 32'(addr_err_out), 32'd0);
`endif
    rstn = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle.stall", 32'(mem_stall_out), 32'd0);

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr,
              vecs[i].wdata, vecs[i].bus, vecs[i].adly, vecs[i].ddly, vecs[i].hold, -1,
              vecs[i].exp_rdata, vecs[i].exp_wdata);

    // Flush mid-WAIT: drain without done, then the next access issues normally.
    run_txn("flush_wait", 1, 0, 2'd2, 0, 32'h300, 32'h0, 32'hCAFEF00D, 1, 2, 0, 4, 32'h0, 32'h0);
    run_txn("after_fl", 1, 0, 2'd2, 0, 32'h304, 32'h0, 32'h0BADF00D, 0, 0, 0, -1, 32'h0BADF00D, 32'h0);
    // Flush while the request is still unaccepted.
    run_txn("flush_req", 0, 1, 2'd2, 0, 32'h308, 32'h11, 32'h0, 2, 0, 0, 2, 32'h0, 32'h0);

    // Reset while in REQ.
    @(posedge clk); #1;
    mem_read_in = 1; mem_size_in = 2'd2; mem_addr_in = 32'h400;
    @(negedge clk);
    check("rst_req.stall_c0", 32'(mem_stall_out), 32'd1);
    @(posedge clk); #1;
    mem_read_in = 0; rstn = 1;
    @(negedge clk);
    check("rst_req.req_c1", 32'(data_req), 32'd1);
    @(posedge clk); #1;
    rstn = 0;
    @(negedge clk);
    check("rst_req.req_c2", 32'(data_req), 32'd0);
    check("rst_req.stall_c2", 32'(mem_stall_out), 32'd0);
    check("rst_req.done_c2", 32'(mem_done_out), 32'd0);
    $display("txn rst_req    reset in REQ, data_req=%0d stall=%0d", data_req, mem_stall_out);
    run_txn("after_rst", 1, 0, 2'd0, 0, 32'h402, 32'h0, 32'hA1B2C3D4, 0, 0, 0, -1, 32'h000000B2, 32'h0);

`ifdef DATA_SRAM_IF_ALIGN_CHECK_EN
    @(posedge clk); #1;
    mem_read_in = 1; mem_size_in = 2'd2; mem_addr_in = 32'h101;
    @(negedge clk);
    check("mis.stall_c0", 32'(mem_stall_out), 32'd1);
    @(posedge clk); #1;
    mem_read_in = 0;
    @(negedge clk);
    check("mis.addr_err_c1", 32'(addr_err_out), 32'd1);
    check("mis.done_c1", 32'(mem_done_out), 32'd1);
    check("mis.rdata_c1", mem_rdata_out, 32'd0);
    check("mis.req_c1", 32'(data_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis.done_c2", 32'(mem_done_out), 32'd0);
    check("mis.req_c2", 32'(data_req), 32'd0);
    $display("txn misalign   word load 0x101 trapped");
`else
    run_txn("mis_bus", 1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h55667788, 0, 0, 0, -1, 32'h55667788, 32'h0);
`endif

    for (int i = 0; i < 40; i++) begin
      rd   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 2));
      sg   = 1'($urandom_range(0, 1));
      addr = $urandom;
      if (sz == 2'd1) addr[0] = 1'b0;
      if (sz == 2'd2) addr[1:0] = 2'b00;
      wd   = $urandom;
      bus  = $urandom;
      adly = $urandom_range(0, 3);
      ddly = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      run_txn($sformatf("rnd%0d", i), rd, !rd, sz, sg, addr, wd, bus, adly, ddly, hold, -1,
              ref_load(bus, addr, sz, sg), ref_store(wd, sz));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_sram_if.md
# data_sram_if

Data-side memory interface of the cqu_mips core. It sits directly downstream of the memory-access stage. It turns that stage's load/store request (read/write strobe, size, sign, address, store data) into a single sram-like bus transaction. It aligns store data to byte lanes, and extracts and sign/zero-extends load data. It holds `mem_stall_out` high until the transaction completes.

## Interface
- `DATA_W`, 32 — data/address width; only 32 is supported.
- `clk` in 1 — single clock; all logic on the rising edge.
- `rstn` in 1 — synchronous, active-high reset: asserted when 1, sampled on `clk`.
- `mem_read_in` in 1 — load request from the memory stage.
- `mem_write_in` in 1 — store request; mutually exclusive with `mem_read_in`.
- `mem_size_in` in 2 — 00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_sign_in` in 1 — 1 = sign-extend load result, 0 = zero-extend.
- `mem_addr_in` in 32 — byte address.
- `mem_wdata_in` in 32 — store data, right-aligned.
- `flush_in` in 1 — kill the current memory-stage instruction.
- `stage_stall_in` in 1 — downstream/other stall; holds the completed result.
- `mem_rdata_out` out 32 — extended load data; valid while `mem_done_out`=1.
- `mem_done_out` out 1 — access complete.
- `mem_stall_out` out 1 — memory stage must hold.
- `addr_err_out` out 1 — misaligned access; present only with the macro.
- `data_req`, `data_wr` out 1 — sram-like request and write flag.
- `data_size` out 2 — sram-like size.
- `data_addr`, `data_wdata` out 32 — sram-like address and write data.
- `data_rdata` in 32 — sram-like read data.
- `data_addr_ok`, `data_data_ok` in 1 — sram-like handshakes.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. At most one outstanding transaction.
- An access is valid when (`mem_read_in` | `mem_write_in`) & !`flush_in`.
- IDLE: on a valid access, register the bus fields and go to REQ. Otherwise stay.
- REQ: `data_req`=1 with registered fields held stable. On `data_addr_ok` go to WAIT.
- WAIT: on `data_data_ok`, capture `data_rdata` and go to DONE. Stores ignore the captured data.
- DONE: `mem_done_out`=1. Hold DONE while `stage_stall_in`=1; otherwise go to IDLE.
- Store lanes:
  - byte → `{4{wdata[7:0]}}`
  - half → `{2{wdata[15:0]}}`
  - word → unchanged.
  - `data_addr` is the full byte address; `data_size` = `mem_size_in`.
- Load extract:
  - byte lane selected by `addr[1:0]`.
  - half selected by `addr[1]`.
  - extended per `mem_sign_in` using the size and address latched at issue.
- `mem_stall_out` = (IDLE & valid access) | REQ | WAIT. It is 0 in DONE.
- Flush in REQ or WAIT:
  - Set a discard flag. `data_req` is NOT withdrawn before `addr_ok`.
  - On `data_ok`, go to IDLE without DONE and with `mem_done_out`=0.
  - Stall stays asserted until the drain completes.
- Flush in DONE: go to IDLE; `mem_done_out` still reflects DONE that cycle.
- `data_addr_ok` outside REQ and `data_data_ok` outside WAIT are ignored.

## Timing
- Reset values: state IDLE, discard 0, all outputs 0 (`data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `mem_rdata_out`, `mem_done_out`, `addr_err_out`).
- `mem_stall_out`=0 when no access is presented.
- Best case, with `addr_ok` in the first REQ cycle and `data_ok` one cycle later:
  - access presented cycle 0
  - `data_req` cycle 1
  - `data_ok` cycle 2
  - `mem_done_out` and data cycle 3
  - minimum 3-cycle latency; stall high cycles 0–2.
- Each extra wait cycle on `addr_ok` or `data_ok` adds one cycle.
- Reset mid-transaction returns to IDLE next edge. The bus slave shares this reset, so no response is awaited.
- `mem_rdata_out` is registered and stable for the whole DONE residency.

## Configuration
- `DATA_SRAM_IF_ALIGN_CHECK_EN` defined: misaligned accesses are detected.
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Such an access issues no bus request.
  - It goes IDLE→DONE in one cycle with `addr_err_out`=1, `mem_done_out`=1 and `mem_rdata_out`=0.
- Undefined: no check. `addr_err_out` is absent, and misaligned addresses go to the bus unchanged.

## Structure
- Shared package `cqu_mips_pkg`:
  - size encodings `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`
  - FSM state enum `dsif_state_t`.
- One natural combinational sub-module, `load_align`: lane select plus sign/zero extension. Store replication stays inline.

## Test plan
- Word store, addr 0x100, wdata 0xDEADBEEF, `addr_ok` immediate, `data_ok` next cycle → `data_req` 1 cycle, `data_wr`=1, `data_wdata`=0xDEADBEEF, `mem_done_out` cycle 3, stall cycles 0–2.
- Byte load, addr 0x103, sign=1, `data_rdata`=0x80112233 → `mem_rdata_out`=0xFFFFFF80. With sign=0 → 0x00000080.
- Half store, addr 0x202, wdata 0x0000ABCD → `data_wdata`=0xABCDABCD, `data_size`=01. `addr_ok` delayed 3 cycles → fields stable, done at cycle 6.
- Flush asserted in WAIT of a load → `mem_done_out` never pulses; stall stays until `data_ok`; next access issues normally.
- `stage_stall_in`=1 for 2 cycles at DONE → `mem_done_out` and `mem_rdata_out` held, no second `data_req`.
- Reset in REQ → next cycle `data_req`=0, state IDLE. With `DATA_SRAM_IF_ALIGN_CHECK_EN`, word load at 0x101 → `addr_err_out`=1 in cycle 1, no `data_req`.
